// File: rtl/risc_ctrl_seq.sv
// Instruction sequencer: FETCH/DECODE/EXEC/WB per instruction, 4 clocks each; hold stalls in FETCH only.
// Decode outputs are registered and carry the instruction fields for exactly the EXEC cycle.
module risc_ctrl_seq #(
  parameter int PC_W   = 8,
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic [PC_W-1:0]   imaddr,
  output logic              imen,
  input  logic [15:0]       imdata,
  output logic [3:0]        opcode,
  output logic [3:0]        dmaddrin,
  output logic [2:0]        dstin,
  output logic [2:0]        opnda_addr,
  output logic [2:0]        opndb_addr,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic [ICNT_W-1:0] icount_nxt;
  logic              is_halt;
  logic              load_ir;

  assign is_halt = (imdata == 16'h0FFF);
  assign load_ir = (state == S_DECODE) && !is_halt;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    icount_nxt = icount;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt  = S_FETCH;
          pc_nxt     = '0;
          icount_nxt = '0;
        end
      end
      S_FETCH: begin
        if (!hold) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        pc_nxt    = pc + 1'b1;
        state_nxt = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        state_nxt = S_FETCH;
        if (icount != {ICNT_W{1'b1}}) icount_nxt = icount + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status and memory-port outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      icount <= '0;
      imen   <= 1'b0;
      imaddr <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      icount <= icount_nxt;
      imen   <= (state_nxt == S_FETCH);
      imaddr <= pc_nxt;
      busy   <= (state_nxt == S_FETCH) || (state_nxt == S_DECODE) ||
                (state_nxt == S_EXEC)  || (state_nxt == S_WB);
      halted <= (state_nxt == S_HALT);
    end
  end

  // These registers are the instruction register: loaded entering EXEC, cleared leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode     <= 4'd0;
      dstin      <= 3'd0;
      opnda_addr <= 3'd0;
      opndb_addr <= 3'd0;
      dmaddrin   <= 4'd0;
    end else if (load_ir) begin
      opcode     <= imdata[15:12];
      dstin      <= imdata[11:9];
      opnda_addr <= imdata[11:9];
      opndb_addr <= imdata[8:6];
      dmaddrin   <= imdata[3:0];
    end else begin
      opcode     <= 4'd0;
      dstin      <= 3'd0;
      opnda_addr <= 3'd0;
      opndb_addr <= 3'd0;
      dmaddrin   <= 4'd0;
    end
  end

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Bench for risc_ctrl_seq: table-driven programs with an EXEC scoreboard, plus hold, wrap, saturation and reset sequences.
module tb_risc_ctrl_seq;

  typedef struct {
    logic [15:0] word;
    logic [3:0]  op;
    logic [2:0]  dst;
    logic [2:0]  b;
    logic [3:0]  dma;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    logic [2:0] dst;
    logic [2:0] b;
    logic [3:0] dma;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, hold;
  logic [7:0]  imaddr;
  logic        imen;
  logic [15:0] imdata = 16'h0;
  logic [3:0]  opcode, dmaddrin;
  logic [2:0]  dstin, opnda_addr, opndb_addr;
  logic        busy, halted;
  logic [7:0]  pc;
  logic [15:0] icount;

  logic        start2, hold2;
  logic [1:0]  imaddr2;
  logic        imen2;
  logic [15:0] imdata2 = 16'h0;
  logic [3:0]  opcode2, dmaddrin2;
  logic [2:0]  dstin2, opnda_addr2, opndb_addr2;
  logic        busy2, halted2;
  logic [1:0]  pc2;
  logic [2:0]  icount2;

  logic [15:0] mem [256];
  logic [15:0] mem2 [4];
  vec_t        tbl [8];
  exp_t        sbq [$];
  int          cyc = 0;
  int          ncmp = 0;
  int          nfail = 0;

  risc_ctrl_seq #(.PC_W(8), .ICNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .imaddr(imaddr), .imen(imen), .imdata(imdata),
    .opcode(opcode), .dmaddrin(dmaddrin), .dstin(dstin),
    .opnda_addr(opnda_addr), .opndb_addr(opndb_addr),
    .busy(busy), .halted(halted), .pc(pc), .icount(icount)
  );

  risc_ctrl_seq #(.PC_W(2), .ICNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .hold(hold2),
    .imaddr(imaddr2), .imen(imen2), .imdata(imdata2),
    .opcode(opcode2), .dmaddrin(dmaddrin2), .dstin(dstin2),
    .opnda_addr(opnda_addr2), .opndb_addr(opndb_addr2),
    .busy(busy2), .halted(halted2), .pc(pc2), .icount(icount2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imen)  imdata  <= mem[imaddr];
    if (imen2) imdata2 <= mem2[imaddr2];
  end

  // Every non-nop EXEC cycle must match the next scoreboard entry, including its cycle.
  always @(negedge clk) begin
    if (rst_n && opcode !== 4'd0) begin
      ncmp++;
      if (sbq.size() == 0) begin
        nfail++;
        $display("FAIL exec_unexpected: got op=%0h dst=%0d at cycle %0d, required no instruction", opcode, dstin, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (opcode !== e.op || dstin !== e.dst || opnda_addr !== e.dst ||
            opndb_addr !== e.b || dmaddrin !== e.dma || cyc != e.cyc) begin
          nfail++;
          $display("FAIL exec: got op=%0h dst=%0d a=%0d b=%0d dma=%0h cyc=%0d, required op=%0h dst=%0d a=%0d b=%0d dma=%0h cyc=%0d",
                   opcode, dstin, opnda_addr, opndb_addr, dmaddrin, cyc,
                   e.op, e.dst, e.dst, e.b, e.dma, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v, input int c);
    exp_t e;
    e.op = v.op; e.dst = v.dst; e.b = v.b; e.dma = v.dma; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic pulse_start(output int c);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      ncmp++;
      nfail++;
      $display("FAIL %s: halted stayed 0, required 1 within 300 cycles", nm);
    end
  endtask

  task automatic wait_icount2(input logic [2:0] target);
    int n = 0;
    while (icount2 !== target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (icount2 !== target) begin
      ncmp++;
      nfail++;
      $display("FAIL wrap_wait: icount2 got %0d, required %0d within 300 cycles", icount2, target);
    end
  endtask

  initial begin
    int c;
    tbl[0] = '{16'h1E00, 4'h1, 3'd7, 3'd0, 4'h0};
    tbl[1] = '{16'h2380, 4'h2, 3'd1, 3'd6, 4'h0};
    tbl[2] = '{16'hE205, 4'hE, 3'd1, 3'd0, 4'h5};
    tbl[3] = '{16'h0000, 4'h0, 3'd0, 3'd0, 4'h0};
    tbl[4] = '{16'h0FFE, 4'h0, 3'd0, 3'd0, 4'h0};
    tbl[5] = '{16'hF3F7, 4'hF, 3'd1, 3'd7, 4'h7};
    tbl[6] = '{16'h7A4C, 4'h7, 3'd5, 3'd1, 4'hC};
    tbl[7] = '{16'h3CB6, 4'h3, 3'd6, 3'd2, 4'h6};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 4; i++) mem2[i] = 16'h0;
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; start2 = 1'b0; hold2 = 1'b0;

    // Reset values, then idle without start.
    repeat (2) @(negedge clk);
    chk("rst_opcode", opcode, 0);
    chk("rst_imen", imen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_icount", icount, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_imen", imen, 0);
    chk("idle_pc", pc, 0);

    // Table program: every entry executed in order, then halt.
    for (int i = 0; i < 8; i++) mem[i] = tbl[i].word;
    mem[8] = 16'h0FFF;
    pulse_start(c);
    chk("run_busy", busy, 1);
    for (int i = 0; i < 8; i++)
      if (tbl[i].op != 4'h0) push_exp(tbl[i], c + 3 + 4 * i);
    wait_halt("tbl_halt");
    chk("tbl_pc", pc, 9);
    chk("tbl_icount", icount, 8);
    chk("tbl_busy", busy, 0);
    chk("tbl_imen", imen, 0);
    chk("tbl_halt_opcode", opcode, 0);

    // Restart from HALT; a second start while busy must be ignored.
    mem[0] = 16'h1E00; mem[1] = 16'h2380; mem[2] = 16'h0FFF;
    pulse_start(c);
    chk("restart_halted", halted, 0);
    push_exp(tbl[0], c + 3);
    push_exp(tbl[1], c + 7);
    while (cyc < c + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt("prog_halt");
    chk("prog_halted", halted, 1);
    chk("prog_pc", pc, 3);
    chk("prog_icount", icount, 2);

    // hold for 5 FETCH cycles delays everything by 5, then normal cadence.
    @(negedge clk);
    start = 1'b1; hold = 1'b1;
    c = cyc;
    push_exp(tbl[0], c + 8);
    push_exp(tbl[1], c + 12);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_imen", imen, 1);
      chk("hold_pc", pc, 0);
      chk("hold_opcode", opcode, 0);
      chk("hold_busy", busy, 1);
      if (i < 4) @(negedge clk);
    end
    @(negedge clk);
    hold = 1'b0;
    wait_halt("hold_halt");
    chk("hold_icount", icount, 2);
    chk("hold_final_pc", pc, 3);

    // Asynchronous reset during EXEC of the second instruction (add).
    mem[0] = 16'h2380; mem[1] = 16'h1E00; mem[2] = 16'h0FFF;
    pulse_start(c);
    push_exp(tbl[1], c + 3);
    push_exp(tbl[0], c + 7);
    begin
      int n = 0;
      while (opcode !== 4'h1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pre_rst_icount", icount, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_opcode", opcode, 0);
    chk("arst_dstin", dstin, 0);
    chk("arst_busy", busy, 0);
    chk("arst_imen", imen, 0);
    chk("arst_pc", pc, 0);
    chk("arst_icount", icount, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    pulse_start(c);
    push_exp(tbl[1], c + 3);
    push_exp(tbl[0], c + 7);
    wait_halt("rerun_halt");
    chk("rerun_pc", pc, 3);
    chk("rerun_icount", icount, 2);

    // Narrow instance: pc wraps 3->0 and the 3-bit counter saturates.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_icount2(3'd4);
    chk("wrap_pc", pc2, 0);
    chk("wrap_busy", busy2, 1);
    repeat (4) @(negedge clk);
    chk("wrap_icount5", icount2, 5);
    chk("wrap_pc1", pc2, 1);
    wait_icount2(3'd7);
    repeat (12) @(negedge clk);
    chk("sat_icount", icount2, 7);
    chk("sat_busy", busy2, 1);
    chk("sat_halted", halted2, 0);

    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
